// File: rtl/ddr3_capture_writer_pkg.sv
// Shared definitions for the DDR3 capture writer: default widths, the capture
// state encoding and the byte order of the packed 16-bit write word.
package ddr3_cap_pkg;

  localparam int unsigned SMP_W_DEF    = 8;
  localparam int unsigned LEN_W_DEF    = 28;
  localparam int unsigned DIV_W_DEF    = 16;
  localparam int unsigned LOAD_CYC_DEF = 4;
  localparam int unsigned WORD_W_DEF   = 2 * SMP_W_DEF;

  // Sample slot index inside a packed word: the earlier sample sits low.
  localparam int unsigned WORD_LO_IDX = 0;
  localparam int unsigned WORD_HI_IDX = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

endpackage

// File: rtl/ddr3_capture_writer_if.sv
// Write-side link between the capture writer and the DDR3 controller.
//   wr_load     : one-cycle pulse rewinding the controller write address
//   wfifo_wren  : write-FIFO write enable
//   wfifo_din   : packed write word
//   wrfifo_full : write-FIFO full (back-pressure towards the writer)
// master = capture writer, slave = controller write port.
interface ddr3_capture_writer_if #(
  parameter int unsigned WORD_W = ddr3_cap_pkg::WORD_W_DEF
);
  logic              wr_load;
  logic              wfifo_wren;
  logic [WORD_W-1:0] wfifo_din;
  logic              wrfifo_full;

  modport master (
    output wr_load,
    output wfifo_wren,
    output wfifo_din,
    input  wrfifo_full
  );

  modport slave (
    input  wr_load,
    input  wfifo_wren,
    input  wfifo_din,
    output wrfifo_full
  );
endinterface

// File: rtl/ddr3_capture_writer_cap_rate_div.sv
// Sample-rate divider: counts 0..div and wraps, flagging the terminal count.
//   clk, rst : clock and synchronous active-high reset
//   clr      : holds the count at 0 and suppresses the strobe
//   div      : terminal count; a strobe occurs every div+1 cycles
//   strobe   : high in the cycle the count equals div (combinational)
module cap_rate_div #(
  parameter int unsigned DIV_W = ddr3_cap_pkg::DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt;

  // Wrapping counter, modulo div+1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign strobe = !clr && (cnt == div);

endmodule

// File: rtl/ddr3_capture_writer.sv
// Sample-capture front end for the DDR3 controller write port. After an arm it
// pulses wr_load, waits LOAD_CYC cycles, then samples din at the divided rate
// until a mask/value trigger hits, and packs sample pairs into words pushed to
// the write FIFO until cfg_len words have been produced.
//   clk, rst            : capture clock, synchronous active-high reset
//   init_calib_complete : DDR3 calibration done; arm is ignored while low
//   arm, abort          : single-cycle start / stop requests
//   cfg_div             : sample strobe every cfg_div+1 cycles
//   cfg_trig_mask/val   : trigger compare mask and value
//   cfg_len             : words to capture (0 behaves as 1)
//   din                 : sample bus
//   wf                  : write-FIFO / address-rewind link (master side)
//   busy, done          : LOAD/ARMED/CAPTURE and DONE indicators
//   overflow            : sticky, a word was dropped on a full FIFO
//   words_cnt           : words produced in the current capture
module ddr3_capture_writer
  import ddr3_cap_pkg::*;
#(
  parameter int unsigned SMP_W    = SMP_W_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned LOAD_CYC = LOAD_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [SMP_W-1:0]      cfg_trig_mask,
  input  logic [SMP_W-1:0]      cfg_trig_val,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [SMP_W-1:0]      din,
  ddr3_capture_writer_if.master wf,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [LEN_W-1:0]      words_cnt
);

  localparam int unsigned WORD_W     = 2 * SMP_W;
  localparam int unsigned LOAD_CNT_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  cap_state_e             state;
  logic [LOAD_CNT_W-1:0]  load_cnt;
  logic [LEN_W-1:0]       len_q;
  logic [DIV_W-1:0]       div_q;
  logic [SMP_W-1:0]       mask_q;
  logic [SMP_W-1:0]       val_q;
  logic [SMP_W-1:0]       low_q;
  logic                   half_q;

  logic                   div_clr;
  logic                   strobe;
  logic                   trig_hit;
  logic [WORD_W-1:0]      packed_word;

  // Divider only runs while waiting for the trigger or capturing.
  assign div_clr  = (state != ST_ARMED) && (state != ST_CAPTURE);
  assign trig_hit = ((din & mask_q) == (val_q & mask_q));

  cap_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr),
    .div    (div_q),
    .strobe (strobe)
  );

  // Held low sample in the earlier slot, current sample in the later slot.
  always_comb begin
    packed_word = '0;
    packed_word[WORD_LO_IDX*SMP_W +: SMP_W] = low_q;
    packed_word[WORD_HI_IDX*SMP_W +: SMP_W] = din;
  end

  // Capture FSM, packer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      load_cnt      <= '0;
      len_q         <= '0;
      div_q         <= '0;
      mask_q        <= '0;
      val_q         <= '0;
      low_q         <= '0;
      half_q        <= 1'b0;
      wf.wr_load    <= 1'b0;
      wf.wfifo_wren <= 1'b0;
      wf.wfifo_din  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      words_cnt     <= '0;
    end else begin
      wf.wr_load    <= 1'b0;
      wf.wfifo_wren <= 1'b0;

      if (abort && (state != ST_IDLE)) begin
        // Pending half word is dropped; overflow and words_cnt are kept.
        state  <= ST_IDLE;
        half_q <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (arm && init_calib_complete) begin
              state      <= ST_LOAD;
              load_cnt   <= '0;
              len_q      <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
              div_q      <= cfg_div;
              mask_q     <= cfg_trig_mask;
              val_q      <= cfg_trig_val;
              half_q     <= 1'b0;
              overflow   <= 1'b0;
              words_cnt  <= '0;
              done       <= 1'b0;
              busy       <= 1'b1;
              wf.wr_load <= 1'b1;
            end
          end

          ST_LOAD: begin
            if (load_cnt == LOAD_CNT_W'(LOAD_CYC - 1)) begin
              state <= ST_ARMED;
            end else begin
              load_cnt <= load_cnt + LOAD_CNT_W'(1);
            end
          end

          ST_ARMED: begin
            // Triggering sample becomes the low half of word 0.
            if (strobe && trig_hit) begin
              low_q  <= din;
              half_q <= 1'b1;
              state  <= ST_CAPTURE;
            end
          end

          ST_CAPTURE: begin
            if (strobe) begin
              if (!half_q) begin
                low_q  <= din;
                half_q <= 1'b1;
              end else begin
                // Word counts even when dropped, so capture length stays fixed in samples.
                half_q    <= 1'b0;
                words_cnt <= words_cnt + LEN_W'(1);
                if (wf.wrfifo_full) begin
                  overflow <= 1'b1;
                end else begin
                  wf.wfifo_wren <= 1'b1;
                  wf.wfifo_din  <= packed_word;
                end
                if ((words_cnt + LEN_W'(1)) == len_q) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_capture_writer.sv
// Directed bench for ddr3_capture_writer with hand-computed expectations.
module tb_ddr3_capture_writer;
  import ddr3_cap_pkg::*;

  logic        clk;
  logic        rst;
  logic        init_calib_complete;
  logic        arm;
  logic        abort;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_trig_mask;
  logic [7:0]  cfg_trig_val;
  logic [27:0] cfg_len;
  logic [7:0]  din;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [27:0] words_cnt;

  ddr3_capture_writer_if wf ();

  ddr3_capture_writer dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .arm                 (arm),
    .abort               (abort),
    .cfg_div             (cfg_div),
    .cfg_trig_mask       (cfg_trig_mask),
    .cfg_trig_val        (cfg_trig_val),
    .cfg_len             (cfg_len),
    .din                 (din),
    .wf                  (wf),
    .busy                (busy),
    .done                (done),
    .overflow            (overflow),
    .words_cnt           (words_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        din_inc  = 1'b0;
  int          n_wren;
  int          n_load;
  logic [15:0] wwords [8];
  int          wtick  [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (din_inc) din = din + 8'd1;
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [7:0] mask,
                         input logic [7:0] val, input logic [27:0] len);
    cfg_div       = div;
    cfg_trig_mask = mask;
    cfg_trig_val  = val;
    cfg_len       = len;
  endtask

  // Pulse arm with din = d0, then run until busy drops or the budget expires.
  // Tick i is the cycle after the i-th edge following the arm cycle.
  task automatic run_cap(input logic [7:0] d0, input int max_cyc, input int full_at,
                         input int abort_at, input int arm_at, input int rst_at);
    n_wren  = 0;
    n_load  = 0;
    din     = d0;
    din_inc = 1'b1;
    arm     = 1'b1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      arm            = (i == arm_at);
      wf.wrfifo_full = (i == full_at);
      abort          = (i == abort_at);
      rst            = (i == rst_at);
      if (wf.wr_load) n_load++;
      if (wf.wfifo_wren) begin
        if (n_wren < 8) begin
          wwords[n_wren] = wf.wfifo_din;
          wtick[n_wren]  = i;
        end
        n_wren++;
      end
      if (!busy) break;
    end
    arm            = 1'b0;
    wf.wrfifo_full = 1'b0;
    abort          = 1'b0;
    rst            = 1'b0;
    din_inc        = 1'b0;
    check("run_ended", 32'(busy), 32'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    init_calib_complete = 1'b1;
    arm                 = 1'b0;
    abort               = 1'b0;
    din                 = 8'h00;
    wf.wrfifo_full      = 1'b0;
    set_cfg(16'd0, 8'h00, 8'h00, 28'd3);
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(words_cnt), 32'd0);
    check("rst_wren", 32'(wf.wfifo_wren), 32'd0);
    check("rst_load", 32'(wf.wr_load), 32'd0);
    check("rst_din", 32'(wf.wfifo_din), 32'd0);
    rst = 1'b0;
    tick();

    // Basic: din 0x10 on first ARMED cycle (tick 5), words at ticks 7/9/11.
    set_cfg(16'd0, 8'h00, 8'h00, 28'd3);
    run_cap(8'h0B, 40, -1, -1, -1, -1);
    check("basic_loads", 32'(n_load), 32'd1);
    check("basic_nwren", 32'(n_wren), 32'd3);
    check("basic_w0", 32'(wwords[0]), 32'h1110);
    check("basic_w1", 32'(wwords[1]), 32'h1312);
    check("basic_w2", 32'(wwords[2]), 32'h1514);
    check("basic_t0", 32'(wtick[0]), 32'd7);
    check("basic_t2", 32'(wtick[2]), 32'd11);
    check("basic_done", 32'(done), 32'd1);
    check("basic_cnt", 32'(words_cnt), 32'd3);
    check("basic_ovf", 32'(overflow), 32'd0);
    tick();
    check("basic_wren_low", 32'(wf.wfifo_wren), 32'd0);

    // Trigger on upper nibble 0xA, single word from DONE re-arm.
    set_cfg(16'd0, 8'hF0, 8'hA0, 28'd1);
    run_cap(8'h00, 300, -1, -1, -1, -1);
    check("trig_nwren", 32'(n_wren), 32'd1);
    check("trig_w0", 32'(wwords[0]), 32'hA1A0);
    check("trig_cnt", 32'(words_cnt), 32'd1);
    check("trig_done", 32'(done), 32'd1);

    // Divider 3: trigger on din 8, words {0x0C,0x08} and {0x14,0x10}, 8 cycles apart.
    set_cfg(16'd3, 8'h00, 8'h00, 28'd2);
    run_cap(8'h00, 60, -1, -1, -1, -1);
    check("div_nwren", 32'(n_wren), 32'd2);
    check("div_w0", 32'(wwords[0]), 32'h0C08);
    check("div_w1", 32'(wwords[1]), 32'h1410);
    check("div_t0", 32'(wtick[0]), 32'd13);
    check("div_gap", 32'(wtick[1] - wtick[0]), 32'd8);

    // FIFO full while second word forms (tick 8 cycle, edge 9).
    set_cfg(16'd0, 8'h00, 8'h00, 28'd3);
    run_cap(8'h0B, 40, 8, -1, -1, -1);
    check("full_nwren", 32'(n_wren), 32'd2);
    check("full_w0", 32'(wwords[0]), 32'h1110);
    check("full_w1", 32'(wwords[1]), 32'h1514);
    check("full_ovf", 32'(overflow), 32'd1);
    check("full_cnt", 32'(words_cnt), 32'd3);
    check("full_done", 32'(done), 32'd1);

    // Abort right after the first word.
    set_cfg(16'd0, 8'h00, 8'h00, 28'd4);
    run_cap(8'h0B, 40, -1, 7, -1, -1);
    check("abort_nwren", 32'(n_wren), 32'd1);
    check("abort_cnt", 32'(words_cnt), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    n_wren = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wf.wfifo_wren) n_wren++;
    end
    check("abort_quiet", 32'(n_wren), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);

    // Arm without calibration is ignored.
    init_calib_complete = 1'b0;
    run_cap(8'h0B, 6, -1, -1, -1, -1);
    check("gate_loads", 32'(n_load), 32'd0);
    check("gate_busy", 32'(busy), 32'd0);
    check("gate_cnt", 32'(words_cnt), 32'd1);
    init_calib_complete = 1'b1;

    // Arm while capturing is ignored.
    set_cfg(16'd0, 8'h00, 8'h00, 28'd3);
    run_cap(8'h0B, 40, -1, -1, 8, -1);
    check("rearm_loads", 32'(n_load), 32'd1);
    check("rearm_nwren", 32'(n_wren), 32'd3);
    check("rearm_w2", 32'(wwords[2]), 32'h1514);
    check("rearm_cnt", 32'(words_cnt), 32'd3);

    // Length 0 behaves as 1.
    set_cfg(16'd0, 8'h00, 8'h00, 28'd0);
    run_cap(8'h0B, 40, -1, -1, -1, -1);
    check("len0_nwren", 32'(n_wren), 32'd1);
    check("len0_w0", 32'(wwords[0]), 32'h1110);
    check("len0_cnt", 32'(words_cnt), 32'd1);

    // Reset mid-capture, sampled at the edge where word 2 would form.
    set_cfg(16'd0, 8'h00, 8'h00, 28'd3);
    run_cap(8'h0B, 40, -1, -1, -1, 8);
    check("rstmid_nwren", 32'(n_wren), 32'd1);
    check("rstmid_wren", 32'(wf.wfifo_wren), 32'd0);
    check("rstmid_cnt", 32'(words_cnt), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_din", 32'(wf.wfifo_din), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr3_capture_writer.md
Name: ddr3_capture_writer

Overview:
- Sample-capture front end that feeds the write side of the two-port DDR3 controller.
- Samples an 8-bit input bus at a programmable rate and waits for a mask/value trigger.
- Packs sample pairs into 16-bit words and drives the write-FIFO port: wfifo_wren/wfifo_din, with wrfifo_full as back-pressure.
- Pulses wr_load at each arm so the controller rewinds its write address to app_addr_wr_min.

Parameters:
- SMP_W, 8: sample width; the packed word is 2*SMP_W = 16 bits.
- LEN_W, 28: width of the capture-length and word counters (matches DDR3 address width).
- DIV_W, 16: width of the sample-rate divider.
- LOAD_CYC, 4: number of cycles spent in LOAD (wr_load high for the first one only).

Ports:
- clk  in  1  capture clock; the same clock as the controller's wr_clk.
- rst  in  1  synchronous reset, active-high.
- init_calib_complete  in  1  DDR3 calibration done; arm is ignored while low.
- arm  in  1  single-cycle start request.
- abort  in  1  single-cycle stop request.
- cfg_div  in  DIV_W  a sample strobe occurs every cfg_div+1 cycles.
- cfg_trig_mask  in  SMP_W  trigger compare mask.
- cfg_trig_val  in  SMP_W  trigger compare value.
- cfg_len  in  LEN_W  number of 16-bit words to capture; 0 is treated as 1.
- din  in  SMP_W  sample bus, already synchronous to clk.
- wr_load  out  1  one-cycle pulse that rewinds the controller write address.
- wfifo_wren  out  1  write-FIFO write enable.
- wfifo_din  out  16  packed word: first sample in [7:0], second sample in [15:8].
- wrfifo_full  in  1  write-FIFO full.
- busy  out  1  high in LOAD, ARMED and CAPTURE.
- done  out  1  high in DONE.
- overflow  out  1  sticky; set when a word is dropped because the FIFO was full.
- words_cnt  out  LEN_W  words produced in the current capture.

Behaviour:
- Reset: state=IDLE. wr_load, wfifo_wren, wfifo_din, busy, done, overflow and words_cnt are all 0. The divider and half-word flag are cleared.
- IDLE:
  - arm && init_calib_complete → LOAD.
  - On that edge: latch cfg_len (0→1), cfg_div, mask and val; clear overflow and words_cnt; clear done.
- LOAD:
  - wr_load=1 in the first LOAD cycle only.
  - After LOAD_CYC cycles → ARMED, with the divider cleared to 0.
- Divider:
  - Counts 0..div_latched and wraps.
  - strobe=1 in the cycle the count equals div_latched, so div=0 gives a strobe every cycle.
  - Runs in ARMED and CAPTURE only.
- ARMED:
  - On a strobe where (din & mask) == (val & mask) → CAPTURE.
  - The triggering sample is stored as the low byte of word 0.
  - mask=0 triggers on the first strobe.
- CAPTURE:
  - On a strobe with the half flag clear: store din in the low holding byte and set the half flag.
  - On a strobe with the half flag set: form {din, low}.
    - Next cycle: wfifo_wren=1 for exactly one cycle with that word; words_cnt increments; the half flag clears.
    - Latency is one cycle from the second strobe.
    - If wrfifo_full is high in the cycle the word is formed: wfifo_wren stays 0, overflow is set, words_cnt still increments. Capture length is therefore fixed in samples.
  - When words_cnt reaches len_latched (on the increment cycle) → DONE. No further strobes are processed.
- DONE:
  - done=1 and busy=0.
  - arm && init_calib_complete → LOAD (new capture).
- Ignored requests:
  - arm in LOAD, ARMED or CAPTURE is ignored.
  - arm in IDLE or DONE while init_calib_complete=0 is ignored.
- abort (any state except IDLE) → IDLE next cycle:
  - Any pending half word is discarded.
  - wfifo_wren is 0 from the next cycle on.
  - overflow and words_cnt hold their values.
  - arm and abort in the same cycle: abort wins.
- Counter wrap: words_cnt never exceeds len_latched, so there is no wrap.
- Divider wrap: the divider wraps modulo div_latched+1.
- rst mid-capture returns the block to reset values immediately. wfifo_wren=0 from the reset cycle.

Decomposition:
- Shared package ddr3_cap_pkg holds:
  - the state encoding (IDLE, LOAD, ARMED, CAPTURE, DONE);
  - SMP_W, LEN_W, DIV_W and LOAD_CYC defaults;
  - the packed-word byte-order constants.
- One natural sub-module, cap_rate_div: the divider/strobe generator (clear input, div input, strobe output).
- The FSM, packer and counters stay in the top level.

Test Plan:
- Basic capture:
  - Stimulus: init_calib_complete=1, cfg_div=0, mask=0, cfg_len=3, din incrementing 0x10,0x11,… from the cycle ARMED is entered; pulse arm.
  - Required: one wr_load pulse, then LOAD_CYC cycles later wfifo_din = 0x1110, 0x1312, 0x1514 on three single-cycle wrens; then done=1, words_cnt=3, overflow=0.
- Trigger:
  - Stimulus: mask=0xF0, val=0xA0, din cycles 0x00..0xFF with div=0, cfg_len=1.
  - Required: the only word is 0xA1A0.
- Divider:
  - Stimulus: cfg_div=3, mask=0, cfg_len=2.
  - Required: samples are taken every 4th cycle; wren gaps are 8 cycles; 2 words are written.
- Full back-pressure:
  - Stimulus: wrfifo_full=1 while the second word forms, cfg_len=3.
  - Required: only 2 wrens occur, overflow=1, words_cnt=3, done=1.
- Abort:
  - Stimulus: abort after 1 of 4 words.
  - Required: IDLE next cycle, no further wren, words_cnt=1, busy=0, done=0.
- Gating:
  - Stimulus: arm while init_calib_complete=0.
  - Required: no wr_load, stays IDLE.
  - Stimulus: arm while in CAPTURE.
  - Required: ignored.
  - Stimulus: rst mid-CAPTURE.
  - Required: all outputs 0 in the next cycle.
